// File: rtl/seq_pkg.sv
// Shared definitions for the fetch/decode sequencer: instruction field
// positions, opcode and FSM state enums, and small decode helpers.
package seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_ORR  = 4'h3,
        OP_MOV  = 4'h4,
        OP_MOVI = 4'h5,
        OP_CMP  = 4'h6,
        OP_B    = 4'h7,
        OP_BEQ  = 4'h8,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, HALT} state_t;

    typedef struct packed {
        logic z;
        logic n;
    } flags_t;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RN_MSB  = 7;
    localparam int RN_LSB  = 4;
    localparam int RM_MSB  = 3;
    localparam int RM_LSB  = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] PC_REG = 4'd15;

    // Ops 0-5 produce a register result destined for rd.
    function automatic logic writes_rd(input logic [3:0] op);
        return op <= OP_MOVI;
    endfunction

    function automatic logic sets_flags(input logic [3:0] op);
        return (op <= OP_ORR) || (op == OP_CMP);
    endfunction

    // 9..E are unassigned; F is HALT.
    function automatic logic is_illegal(input logic [3:0] op);
        return (op > OP_BEQ) && (op != OP_HALT);
    endfunction

endpackage

// File: rtl/fetch_decode_sequencer_if.sv
// Instruction-memory fetch interface.
//   req  : fetch request (sequencer -> memory)
//   addr : fetch address, the program counter
//   ack  : instruction valid this cycle (memory -> sequencer)
//   data : instruction word
interface fetch_decode_sequencer_if #(
    parameter int BUS     = 8,
    parameter int INSTR_W = 16
);
    logic               req;
    logic [BUS-1:0]     addr;
    logic               ack;
    logic [INSTR_W-1:0] data;

    modport master (output req, output addr, input ack, input data);
    modport slave  (input req, input addr, output ack, output data);
endinterface

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer.
//   op     : instruction opcode
//   a, b   : bank read data for rn and rm
//   imm8   : immediate field
//   result : op result, modulo 2^BUS (carry dropped)
//   z, n   : zero / negative of result
module seq_alu
    import seq_pkg::*;
#(
    parameter int BUS = 8
) (
    input  logic [3:0]     op,
    input  logic [BUS-1:0] a,
    input  logic [BUS-1:0] b,
    input  logic [7:0]     imm8,
    output logic [BUS-1:0] result,
    output logic           z,
    output logic           n
);
    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_ORR:  result = a | b;
            OP_MOV:  result = b;
            OP_MOVI: result = BUS'(imm8);
            OP_CMP:  result = a - b;
            default: result = '0;
        endcase
        z = (result == '0);
        n = result[BUS-1];
    end
endmodule

// File: rtl/fetch_decode_sequencer.sv
// Multicycle fetch/decode/control stage feeding a 16-entry register bank.
// One instruction at a time: FETCH -> DECODE -> EXEC -> WB, no overlap.
//   clk, rst_n      : clock, async active-low reset
//   imem            : instruction fetch interface (master side)
//   da, db, dc, RE  : bank read addresses (rn, rm, rd) and read enable
//   address, WE     : bank write address (rd) and write enable
//   write_data      : bank write data
//   pc_in           : program counter, mirrored into bank r15
//   doa, dob        : bank read data, registered inside the bank
//   halted, illegal : HALT executed / undefined opcode pulse in WB
module fetch_decode_sequencer
    import seq_pkg::*;
#(
    parameter int             BUS      = 8,
    parameter int             DIR      = 4,
    parameter int             INSTR_W  = 16,
    parameter logic [BUS-1:0] RESET_PC = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    fetch_decode_sequencer_if.master  imem,
    output logic [DIR-1:0]            da,
    output logic [DIR-1:0]            db,
    output logic [DIR-1:0]            dc,
    output logic                      RE,
    output logic [DIR-1:0]            address,
    output logic                      WE,
    output logic [BUS-1:0]            write_data,
    output logic [BUS-1:0]            pc_in,
    input  logic [BUS-1:0]            doa,
    input  logic [BUS-1:0]            dob,
    output logic                      halted,
    output logic                      illegal
);
    state_t             state, state_n;
    logic [INSTR_W-1:0] ir_q;
    logic [BUS-1:0]     pc_q, res_q, tgt_q, alu_res, imm_sext;
    logic [DIR-1:0]     addr_q, rd;
    flags_t             flags_q;
    logic               alu_z, alu_n, wr_pc, taken;
    logic [3:0]         op;
    logic [7:0]         imm8;

    assign op       = ir_q[OP_MSB:OP_LSB];
    assign rd       = ir_q[RD_MSB:RD_LSB];
    assign imm8     = ir_q[IMM_MSB:IMM_LSB];
    assign imm_sext = BUS'($signed(imm8));

    assign wr_pc = writes_rd(op) && (rd == PC_REG);
    // BEQ does not touch the flags, so Z is still the value it saw in EXEC.
    assign taken = (op == OP_B) || ((op == OP_BEQ) && flags_q.z);

    seq_alu #(.BUS(BUS)) u_alu (
        .op     (op),
        .a      (doa),
        .b      (dob),
        .imm8   (imm8),
        .result (alu_res),
        .z      (alu_z),
        .n      (alu_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_n;
    end

    always_comb begin
        state_n  = state;
        imem.req = 1'b0;
        RE       = 1'b0;
        WE       = 1'b0;
        illegal  = 1'b0;
        halted   = 1'b0;
        case (state)
            FETCH: begin
                imem.req = 1'b1;
                if (imem.ack) state_n = DECODE;
            end
            DECODE: begin
                RE      = 1'b1;
                state_n = EXEC;
            end
            EXEC: state_n = WB;
            WB: begin
                // Writes to r15 become PC loads; the bank never sees them.
                WE      = writes_rd(op) && (rd != PC_REG);
                illegal = is_illegal(op);
                state_n = (op == OP_HALT) ? HALT : FETCH;
            end
            HALT:    halted  = 1'b1;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            res_q   <= '0;
            tgt_q   <= '0;
            addr_q  <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                FETCH: if (imem.ack) ir_q <= imem.data;
                EXEC: begin
                    res_q  <= alu_res;
                    tgt_q  <= pc_q + imm_sext;
                    addr_q <= rd;
                    if (sets_flags(op)) flags_q <= '{z: alu_z, n: alu_n};
                end
                WB: begin
                    if (wr_pc)      pc_q <= res_q;
                    else if (taken) pc_q <= tgt_q;
                    else            pc_q <= pc_q + BUS'(1);
                end
                default: ;
            endcase
        end
    end

    // ir_q only changes on entry to DECODE, so the read addresses hold
    // their last values everywhere else; address/write_data likewise only
    // change at the end of EXEC.
    assign da         = ir_q[RN_MSB:RN_LSB];
    assign db         = ir_q[RM_MSB:RM_LSB];
    assign dc         = rd;
    assign address    = addr_q;
    assign write_data = res_q;
    assign imem.addr  = pc_q;
    assign pc_in      = pc_q;
endmodule
